// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use detection and ALU control decode
module id_ex_stage #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] RS1Data,
    input  logic [REG_WIDTH-1:0] RS2Data,
    input  logic [REG_WIDTH-1:0] Imm,
    input  logic [4:0]           Rs1,
    input  logic [4:0]           Rs2,
    input  logic [4:0]           Rd,
    input  logic [1:0]           ALUOp,
    input  logic [2:0]           Funct3,
    input  logic                 Funct7b5,
    input  logic                 ALUSrc,
    input  logic                 RegWrite,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 flush,
    input  logic                 ExMemRegWrite,
    input  logic [4:0]           ExMemRd,
    input  logic [REG_WIDTH-1:0] ExMemData,
    input  logic                 MemWbRegWrite,
    input  logic [4:0]           MemWbRd,
    input  logic [REG_WIDTH-1:0] MemWbData,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           ALUCtl,
    output logic [REG_WIDTH-1:0] A,
    output logic [REG_WIDTH-1:0] B,
    output logic [REG_WIDTH-1:0] StoreData,
    output logic [4:0]           out_Rd,
    output logic                 out_RegWrite,
    output logic                 out_MemRead,
    output logic                 out_MemWrite,
    output logic                 LoadUseStall
);

    logic [REG_WIDTH-1:0] q_rs1data, q_rs2data, q_imm;
    logic [4:0]           q_rs1, q_rs2, q_rd;
    logic [1:0]           q_aluop;
    logic [2:0]           q_funct3;
    logic                 q_funct7b5, q_alusrc, q_regwrite, q_memread, q_memwrite;
    logic                 capture;
    logic [REG_WIDTH-1:0] fwd_a, fwd_b;

    // A load in the register feeding the incoming instruction must let one bubble through
    assign LoadUseStall = out_valid && q_memread && (q_rd != 5'd0) && in_valid &&
                          ((Rs1 == q_rd) || ((Rs2 == q_rd) && (!ALUSrc || MemWrite)));
    assign in_ready     = (!out_valid || out_ready) && !LoadUseStall && !flush;
    assign capture      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            q_rs1data  <= '0;
            q_rs2data  <= '0;
            q_imm      <= '0;
            q_rs1      <= '0;
            q_rs2      <= '0;
            q_rd       <= '0;
            q_aluop    <= '0;
            q_funct3   <= '0;
            q_funct7b5 <= 1'b0;
            q_alusrc   <= 1'b0;
            q_regwrite <= 1'b0;
            q_memread  <= 1'b0;
            q_memwrite <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (capture) begin
                q_rs1data  <= RS1Data;
                q_rs2data  <= RS2Data;
                q_imm      <= Imm;
                q_rs1      <= Rs1;
                q_rs2      <= Rs2;
                q_rd       <= Rd;
                q_aluop    <= ALUOp;
                q_funct3   <= Funct3;
                q_funct7b5 <= Funct7b5;
                q_alusrc   <= ALUSrc;
                q_regwrite <= RegWrite;
                q_memread  <= MemRead;
                q_memwrite <= MemWrite;
            end
        end
    end

    // EX/MEM is the younger producer, so it takes priority over MEM/WB
    always_comb begin
        fwd_a = q_rs1data;
        if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == q_rs1)) begin
            fwd_a = ExMemData;
        end else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == q_rs1)) begin
            fwd_a = MemWbData;
        end
        fwd_b = q_rs2data;
        if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == q_rs2)) begin
            fwd_b = ExMemData;
        end else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == q_rs2)) begin
            fwd_b = MemWbData;
        end
    end

    assign A         = fwd_a;
    assign B         = q_alusrc ? q_imm : fwd_b;
    assign StoreData = fwd_b;

    always_comb begin
        ALUCtl = 4'b1111;
        case (q_aluop)
            2'b00: ALUCtl = 4'b0010;
            2'b01: ALUCtl = (q_funct3 == 3'b100) ? 4'b0111 : 4'b0110;
            2'b10: begin
                case (q_funct3)
                    3'b000:  ALUCtl = (q_funct7b5 && !q_alusrc) ? 4'b0110 : 4'b0010;
                    3'b111:  ALUCtl = 4'b0000;
                    3'b110:  ALUCtl = 4'b0001;
                    3'b010:  ALUCtl = 4'b0111;
                    default: ALUCtl = 4'b1111;
                endcase
            end
            default: ALUCtl = 4'b1111;
        endcase
    end

    assign out_Rd       = q_rd;
    assign out_RegWrite = out_valid && q_regwrite;
    assign out_MemRead  = out_valid && q_memread;
    assign out_MemWrite = out_valid && q_memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage with a reference model and per-cycle compare
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] RS1Data = '0, RS2Data = '0, Imm = '0;
    logic [4:0]  Rs1 = '0, Rs2 = '0, Rd = '0;
    logic [1:0]  ALUOp = '0;
    logic [2:0]  Funct3 = '0;
    logic        Funct7b5 = 1'b0, ALUSrc = 1'b0, RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        flush = 1'b0;
    logic        ExMemRegWrite = 1'b0, MemWbRegWrite = 1'b0;
    logic [4:0]  ExMemRd = '0, MemWbRd = '0;
    logic [31:0] ExMemData = '0, MemWbData = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [3:0]  ALUCtl;
    logic [31:0] A, B, StoreData;
    logic [4:0]  out_Rd;
    logic        out_RegWrite, out_MemRead, out_MemWrite, LoadUseStall;

    id_ex_stage #(.REG_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .RS1Data(RS1Data), .RS2Data(RS2Data), .Imm(Imm), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7b5(Funct7b5), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .flush(flush),
        .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemData(ExMemData),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
        .out_valid(out_valid), .out_ready(out_ready), .ALUCtl(ALUCtl), .A(A), .B(B),
        .StoreData(StoreData), .out_Rd(out_Rd), .out_RegWrite(out_RegWrite),
        .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite), .LoadUseStall(LoadUseStall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] d1, d2, im;
        logic [4:0]  r1, r2, rd;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7, src, rw, mr, mw;
    } ins_t;

    ins_t m_ins = '0;
    bit   m_valid = 1'b0;

    function automatic bit exp_stall();
        return m_valid && m_ins.mr && m_ins.rd != 0 && in_valid &&
               (Rs1 == m_ins.rd || (Rs2 == m_ins.rd && (!ALUSrc || MemWrite)));
    endfunction

    function automatic bit exp_ready();
        return (!m_valid || out_ready) && !exp_stall() && !flush;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == r) return ExMemData;
        if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == r) return MemWbData;
        return d;
    endfunction

    function automatic logic [3:0] exp_alu(input ins_t i);
        if (i.op == 2'd0) return 4'd2;
        if (i.op == 2'd1) return (i.f3 == 3'd4) ? 4'd7 : 4'd6;
        if (i.op == 2'd3) return 4'd15;
        case (i.f3)
            3'd0:    return (i.f7 && !i.src) ? 4'd6 : 4'd2;
            3'd7:    return 4'd0;
            3'd6:    return 4'd1;
            3'd2:    return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ins   = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && exp_ready()) begin
            m_valid = 1'b1;
            m_ins   = '{RS1Data, RS2Data, Imm, Rs1, Rs2, Rd, ALUOp, Funct3,
                        Funct7b5, ALUSrc, RegWrite, MemRead, MemWrite};
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", out_valid, m_valid);
            check("m_in_ready", in_ready, exp_ready());
            check("m_stall", LoadUseStall, exp_stall());
            check("m_aluctl", ALUCtl, exp_alu(m_ins));
            check("m_a", A, fwd(m_ins.r1, m_ins.d1));
            check("m_b", B, m_ins.src ? m_ins.im : fwd(m_ins.r2, m_ins.d2));
            check("m_store", StoreData, fwd(m_ins.r2, m_ins.d2));
            check("m_rd", out_Rd, m_ins.rd);
            check("m_regwrite", out_RegWrite, m_valid && m_ins.rw);
            check("m_memread", out_MemRead, m_valid && m_ins.mr);
            check("m_memwrite", out_MemWrite, m_valid && m_ins.mw);
        end
    end

    task automatic set_in(input logic [31:0] d1, d2, im, input logic [4:0] r1, r2, rd,
                          input logic [1:0] op, input logic [2:0] f3,
                          input logic f7, src, rw, mr, mw);
        RS1Data = d1; RS2Data = d2; Imm = im; Rs1 = r1; Rs2 = r2; Rd = rd;
        ALUOp = op; Funct3 = f3; Funct7b5 = f7; ALUSrc = src;
        RegWrite = rw; MemRead = mr; MemWrite = mw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] tbl_op [10] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    logic [2:0] tbl_f3 [10] = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd2, 3'd1, 3'd0};
    logic       tbl_f7 [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       tbl_src[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] tbl_exp[10] = '{4'd2, 4'd7, 4'd6, 4'd6, 4'd2, 4'd0, 4'd1, 4'd7, 4'd15, 4'd15};

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_aluctl", ALUCtl, 4'b0010);
        check("rst_a", A, 32'd0);
        check("rst_b", B, 32'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_stall", LoadUseStall, 1'b0);
        step();
        rst_n = 1'b1;

        // add x3,x1,x2
        set_in(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("add_valid", out_valid, 1'b1);
        check("add_aluctl", ALUCtl, 4'b0010);
        check("add_a", A, 32'd5);
        check("add_b", B, 32'd7);

        // forwarding priority on held Rs1=4
        step();
        set_in(32'h99, 32'h44, 32'd0, 5'd4, 5'd4, 5'd10, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        ExMemRegWrite = 1'b1; ExMemRd = 5'd4; ExMemData = 32'h11;
        MemWbRegWrite = 1'b1; MemWbRd = 5'd4; MemWbData = 32'h22;
        @(negedge clk);
        check("fwd_exmem_a", A, 32'h11);
        check("fwd_exmem_store", StoreData, 32'h11);
        step();
        ExMemRegWrite = 1'b0;
        @(negedge clk);
        check("fwd_memwb_a", A, 32'h22);
        step();
        ExMemRegWrite = 1'b1; ExMemRd = 5'd0; MemWbRd = 5'd0;
        @(negedge clk);
        check("fwd_rd0_a", A, 32'h99);
        step();
        ExMemRegWrite = 1'b0; MemWbRegWrite = 1'b0;
        out_ready = 1'b1;
        step();

        // load-use: lw x5 then add using x5
        set_in(32'd0, 32'd0, 32'd8, 5'd1, 5'd0, 5'd5, 2'd0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b1;
        step();
        set_in(32'd1, 32'd2, 32'd0, 5'd5, 5'd2, 5'd6, 2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("lu_stall", LoadUseStall, 1'b1);
        check("lu_in_ready", in_ready, 1'b0);
        step();
        @(negedge clk);
        check("lu_bubble", out_valid, 1'b0);
        check("lu_ready_after", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lu_captured", out_valid, 1'b1);
        check("lu_captured_rd", out_Rd, 5'd6);

        // backpressure: hold X (rd=7) for three cycles, then Y (rd=8)
        set_in(32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd7, 2'd2, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        set_in(32'd9, 32'd9, 32'd0, 5'd1, 5'd2, 5'd8, 2'd2, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rd", out_Rd, 5'd7);
            check("bp_a", A, 32'd3);
            check("bp_aluctl", ALUCtl, 4'b0000);
            check("bp_in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_y_rd", out_Rd, 5'd8);
        check("bp_y_aluctl", ALUCtl, 4'b0001);
        step();
        @(negedge clk);
        check("bp_no_dup", out_valid, 1'b0);

        // ALU control table, back-to-back captures
        for (int i = 0; i < 10; i++) begin
            set_in(32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd9, tbl_op[i][1:0], tbl_f3[i],
                   tbl_f7[i], tbl_src[i], 1'b1, 1'b0, 1'b0);
            in_valid = 1'b1;
            step();
            @(negedge clk);
            check("tbl_valid", out_valid, 1'b1);
            check("tbl_aluctl", ALUCtl, tbl_exp[i]);
        end
        in_valid = 1'b0;
        step();

        // flush with incoming instruction
        set_in(32'd1, 32'd1, 32'd0, 5'd1, 5'd1, 5'd9, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready", in_ready, 1'b0);
        step();
        @(negedge clk);
        check("fl_valid", out_valid, 1'b0);
        check("fl_regwrite", out_RegWrite, 1'b0);
        step();
        flush = 1'b0;

        // asynchronous reset while holding, then release mid-cycle
        step();
        @(negedge clk);
        check("ar_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_now", out_valid, 1'b0);
        check("ar_regwrite_now", out_RegWrite, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("ar_empty_after", out_valid, 1'b0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("ar_first_capture", out_valid, 1'b1);
        step();
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
